// File: rtl/palette_clut.sv
// rtl/palette_clut.sv - double-buffered RGB565 colour look-up table with dim and 2-stage pipeline
module palette_clut #(
  parameter int PAL_BITS = 2,
  parameter int DIM_BITS = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  input  logic [PAL_BITS-1:0] i_color,
  input  logic [DIM_BITS-1:0] i_dim,
  input  logic                i_wr_en,
  input  logic [PAL_BITS-1:0] i_wr_addr,
  input  logic [15:0]         i_wr_data,
  input  logic                i_commit,
  output logic                o_valid,
  output logic [4:0]          o_red,
  output logic [5:0]          o_green,
  output logic [4:0]          o_blue,
  output logic                o_pending
);

  localparam int DEPTH = 1 << PAL_BITS;

  // Power-up palette: white, light grey, a grey-blue, black; anything beyond index 3 is black.
  function automatic logic [15:0] default_entry(input int idx);
    logic [15:0] e;
    case (idx)
      0:       e = {5'd31, 6'd63, 5'd31};
      1:       e = {5'd23, 6'd48, 5'd23};
      2:       e = {5'd15, 6'd34, 5'd19};
      default: e = 16'h0000;
    endcase
    return e;
  endfunction

  logic [15:0]         shadow_q [DEPTH];
  logic [15:0]         shadow_d [DEPTH];
  logic [15:0]         active_q [DEPTH];
  logic [15:0]         active_d [DEPTH];
  logic                pending_q, pending_d;

  logic                s1_valid_q, s1_valid_d;
  logic [PAL_BITS-1:0] s1_color_q, s1_color_d;
  logic [DIM_BITS-1:0] s1_dim_q, s1_dim_d;

  logic                valid_q, valid_d;
  logic [4:0]          red_q, red_d;
  logic [5:0]          green_q, green_d;
  logic [4:0]          blue_q, blue_d;
  logic [15:0]         entry;

  // Table update: commit copies the pre-write shadow, so a same-edge write waits for the next commit.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = i_commit ? shadow_q[i] : active_q[i];
    end
    if (i_wr_en) begin
      shadow_d[i_wr_addr] = i_wr_data;
    end
    if (i_wr_en) begin
      pending_d = 1'b1;
    end else if (i_commit) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // Stage 1 simply captures the pixel request.
  always_comb begin
    s1_valid_d = i_valid;
    s1_color_d = i_color;
    s1_dim_d   = i_dim;
  end

  // Stage 2 looks up the active table, dims each channel and blanks when no pixel is present.
  always_comb begin
    entry   = active_q[s1_color_q];
    valid_d = s1_valid_q;
    red_d   = 5'd0;
    green_d = 6'd0;
    blue_d  = 5'd0;
    if (s1_valid_q) begin
      red_d   = entry[15:11] >> s1_dim_q;
      green_d = entry[10:5]  >> s1_dim_q;
      blue_d  = entry[4:0]   >> s1_dim_q;
    end
  end

  // All state; reset restores the default palette and flushes the pipeline.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        shadow_q[i] <= default_entry(i);
        active_q[i] <= default_entry(i);
      end
      pending_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_color_q <= '0;
      s1_dim_q   <= '0;
      valid_q    <= 1'b0;
      red_q      <= 5'd0;
      green_q    <= 6'd0;
      blue_q     <= 5'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
      pending_q  <= pending_d;
      s1_valid_q <= s1_valid_d;
      s1_color_q <= s1_color_d;
      s1_dim_q   <= s1_dim_d;
      valid_q    <= valid_d;
      red_q      <= red_d;
      green_q    <= green_d;
      blue_q     <= blue_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_red     = red_q;
  assign o_green   = green_q;
  assign o_blue    = blue_q;
  assign o_pending = pending_q;

endmodule

// File: tb/tb_palette_clut.sv
// tb/tb_palette_clut.sv - table-driven scoreboard bench for palette_clut
module tb_palette_clut;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic [1:0]  i_color;
  logic [1:0]  i_dim;
  logic        i_wr_en;
  logic [1:0]  i_wr_addr;
  logic [15:0] i_wr_data;
  logic        i_commit;
  logic        o_valid;
  logic [4:0]  o_red;
  logic [5:0]  o_green;
  logic [4:0]  o_blue;
  logic        o_pending;

  palette_clut #(.PAL_BITS(2), .DIM_BITS(2)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .i_color   (i_color),
    .i_dim     (i_dim),
    .i_wr_en   (i_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_commit  (i_commit),
    .o_valid   (o_valid),
    .o_red     (o_red),
    .o_green   (o_green),
    .o_blue    (o_blue),
    .o_pending (o_pending)
  );

  always #5 i_clk = ~i_clk;

  // One row per clock edge: inputs, the pixel this row's sample must produce, and o_pending after the edge.
  typedef struct {
    logic        rst_n;
    logic        v;
    logic [1:0]  c;
    logic [1:0]  d;
    logic        we;
    logic [1:0]  wa;
    logic [15:0] wd;
    logic        cm;
    logic        ev;
    logic [4:0]  er;
    logic [5:0]  eg;
    logic [4:0]  eb;
    logic        ep;
  } vec_t;

  typedef struct {
    logic       v;
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic rst_n, input logic v, input logic [1:0] c, input logic [1:0] d,
                     input logic we, input logic [1:0] wa, input logic [15:0] wd, input logic cm,
                     input logic ev, input logic [4:0] er, input logic [5:0] eg, input logic [4:0] eb,
                     input logic ep);
    vec_t t;
    t.rst_n = rst_n; t.v = v; t.c = c; t.d = d; t.we = we; t.wa = wa; t.wd = wd; t.cm = cm;
    t.ev = ev; t.er = er; t.eg = eg; t.eb = eb; t.ep = ep;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int row, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s row %0d: got %0d, required %0d", name, row, act, req);
    end
  endtask

  task automatic check_pix(input int row, input exp_t e);
    check("o_valid", row, int'(o_valid), int'(e.v));
    check("o_red",   row, int'(o_red),   int'(e.r));
    check("o_green", row, int'(o_green), int'(e.g));
    check("o_blue",  row, int'(o_blue),  int'(e.b));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e, blank;
    blank.v = 1'b0; blank.r = 5'd0; blank.g = 6'd0; blank.b = 5'd0;

    //   rst v  c  d  we wa wd        cm  ev  r   g   b   pend
    add(0, 0, 0, 0, 0, 0, 16'h0000, 0,  0,  0,  0,  0,  0);   // 0  reset
    add(1, 1, 0, 0, 0, 0, 16'h0000, 0,  1, 31, 63, 31,  0);   // 1  defaults
    add(1, 1, 1, 0, 0, 0, 16'h0000, 0,  1, 23, 48, 23,  0);
    add(1, 1, 2, 0, 0, 0, 16'h0000, 0,  1, 15, 34, 19,  0);
    add(1, 1, 3, 0, 0, 0, 16'h0000, 0,  1,  0,  0,  0,  0);
    add(1, 0, 3, 0, 0, 0, 16'h0000, 0,  0,  0,  0,  0,  0);   // 5  idle blanking
    add(1, 0, 0, 0, 0, 0, 16'h0000, 0,  0,  0,  0,  0,  0);
    add(1, 1, 0, 0, 0, 0, 16'h0000, 0,  1, 31, 63, 31,  0);   // 7  single pulse
    add(1, 0, 0, 0, 0, 0, 16'h0000, 0,  0,  0,  0,  0,  0);
    add(1, 0, 0, 0, 0, 0, 16'h0000, 0,  0,  0,  0,  0,  0);
    add(1, 1, 1, 0, 1, 1, 16'hF800, 0,  1, 23, 48, 23,  1);   // 10 shadow write only
    add(1, 1, 1, 0, 0, 0, 16'h0000, 0,  1, 23, 48, 23,  1);   // 11 sampled before commit: old
    add(1, 1, 1, 0, 0, 0, 16'h0000, 1,  1, 31,  0,  0,  0);   // 12 sampled at commit: new
    add(1, 1, 1, 0, 0, 0, 16'h0000, 0,  1, 31,  0,  0,  0);
    add(1, 1, 2, 0, 1, 2, 16'h07E0, 1,  1, 15, 34, 19,  1);   // 14 write+commit same edge
    add(1, 1, 2, 0, 0, 0, 16'h0000, 0,  1, 15, 34, 19,  1);
    add(1, 1, 2, 0, 0, 0, 16'h0000, 1,  1,  0, 63,  0,  0);   // 16 next commit
    add(1, 1, 1, 0, 0, 0, 16'h0000, 0,  1, 31,  0,  0,  0);
    add(1, 0, 0, 0, 1, 3, 16'h1234, 0,  0,  0,  0,  0,  1);   // 18 repeated writes
    add(1, 0, 0, 0, 1, 3, 16'hFFFF, 0,  0,  0,  0,  0,  1);
    add(1, 1, 3, 0, 0, 0, 16'h0000, 1,  1, 31, 63, 31,  0);   // 20 last write wins
    add(1, 1, 3, 0, 0, 0, 16'h0000, 1,  1, 31, 63, 31,  0);   // 21 commit with nothing pending
    add(1, 1, 0, 1, 0, 0, 16'h0000, 0,  1, 15, 31, 15,  0);   // 22 dim
    add(1, 1, 0, 3, 0, 0, 16'h0000, 0,  1,  3,  7,  3,  0);
    add(1, 1, 1, 2, 0, 0, 16'h0000, 0,  1,  7,  0,  0,  0);
    add(1, 1, 2, 1, 0, 0, 16'h0000, 0,  1,  0, 31,  0,  0);
    add(1, 1, 0, 0, 1, 0, 16'h0000, 0,  1, 31, 63, 31,  1);   // 26 reprogram entry0
    add(1, 1, 0, 0, 0, 0, 16'h0000, 1,  1,  0,  0,  0,  0);
    add(1, 1, 0, 0, 0, 0, 16'h0000, 0,  1,  0,  0,  0,  0);
    add(0, 1, 0, 0, 0, 0, 16'h0000, 0,  0,  0,  0,  0,  0);   // 29 mid-stream reset
    add(1, 1, 0, 0, 0, 0, 16'h0000, 0,  1, 31, 63, 31,  0);
    add(1, 1, 1, 0, 0, 0, 16'h0000, 0,  1, 23, 48, 23,  0);
    add(1, 1, 2, 0, 0, 0, 16'h0000, 0,  1, 15, 34, 19,  0);
    add(1, 1, 3, 0, 0, 0, 16'h0000, 0,  1,  0,  0,  0,  0);
    add(1, 0, 0, 0, 0, 0, 16'h0000, 0,  0,  0,  0,  0,  0);
    add(1, 0, 0, 0, 0, 0, 16'h0000, 0,  0,  0,  0,  0,  0);

    for (int k = 0; k < vecs.size(); k++) begin
      i_rst_n   = vecs[k].rst_n;
      i_valid   = vecs[k].v;
      i_color   = vecs[k].c;
      i_dim     = vecs[k].d;
      i_wr_en   = vecs[k].we;
      i_wr_addr = vecs[k].wa;
      i_wr_data = vecs[k].wd;
      i_commit  = vecs[k].cm;
      @(posedge i_clk);
      #1;
      e.v = vecs[k].ev; e.r = vecs[k].er; e.g = vecs[k].eg; e.b = vecs[k].eb;
      if (!vecs[k].rst_n) begin
        // In-flight pixels are dropped; outputs must already be blank after the reset edge.
        sb.delete();
        check_pix(k, blank);
        sb.push_back(e);
      end else begin
        sb.push_back(e);
        if (sb.size() >= 2) begin
          check_pix(k, sb.pop_front());
        end
      end
      check("o_pending", k, int'(o_pending), int'(vecs[k].ep));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
